// File: rtl/udp_tx_scheduler_if.sv
// Channel-side and sender-side signals of the UDP TX scheduler.
// master = scheduler, slave = channel buffers / udp_sender / MAC.
`timescale 1ns/1ps
interface udp_tx_scheduler_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0]      req;
    logic [16*N_CH-1:0]   len_in;
    logic [31:0]          time_in;
    logic                 tx_rdy;
    logic                 snd_end_tx;
    logic                 snd_en;
    logic [7:0]           snd_channel;
    logic [15:0]          snd_mem_length;
    logic [31:0]          snd_time_buf;
    logic [2:0]           mem_sel;
    logic [N_CH-1:0]      ack;
    logic                 err;
    logic                 busy;
    logic [15:0]          frame_cnt;

    modport master (
        input  req, len_in, time_in, tx_rdy, snd_end_tx,
        output snd_en, snd_channel, snd_mem_length, snd_time_buf,
        output mem_sel, ack, err, busy, frame_cnt
    );

    modport slave (
        output req, len_in, time_in, tx_rdy, snd_end_tx,
        input  snd_en, snd_channel, snd_mem_length, snd_time_buf,
        input  mem_sel, ack, err, busy, frame_cnt
    );
endinterface

// File: rtl/udp_tx_scheduler.sv
// Round-robin scheduler sharing one udp_sender between N_CH channels,
// with length checks, inter-frame gap and a SEND watchdog.
`timescale 1ns/1ps
module udp_tx_scheduler #(
    parameter int N_CH    = 4,
    parameter int CH_BASE = 0,
    parameter int MAX_LEN = 1024,
    parameter int GAP     = 16,
    parameter int TIMEOUT = 8192
) (
    input  logic              clk,
    input  logic              rst_n,
    udp_tx_scheduler_if.master bus
);
    localparam int CW = ($clog2(TIMEOUT) > 14) ? $clog2(TIMEOUT) : 14;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SEND, S_GAP, S_REJ
    } state_t;

    state_t         state, state_n;
    logic [CW-1:0]  cnt;
    logic [2:0]     rr_ptr;
    logic [2:0]     win;
    logic [3:0]     idx;
    logic           found;
    logic [7:0]     req8;
    logic [127:0]   len8;
    logic [15:0]    lens [8];
    logic [15:0]    win_len;
    logic           bad_len;
    logic           grant;
    logic           done;
    logic           abort;

    function automatic logic [N_CH-1:0] onehot(input logic [2:0] i);
        logic [7:0] v;
        v = 8'd1 << i;
        return N_CH'(v);
    endfunction

    assign req8 = 8'(bus.req);
    assign len8 = 128'(bus.len_in);

    // Search starts one past the last granted channel.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 0; i < 8; i++) begin
            lens[i] = len8[16*i +: 16];
        end
        for (int i = 0; i < N_CH; i++) begin
            idx = {1'b0, rr_ptr} + 4'(i);
            if (idx >= 4'(N_CH)) begin
                idx = idx - 4'(N_CH);
            end
            if (!found && req8[idx[2:0]]) begin
                found = 1'b1;
                win   = idx[2:0];
            end
        end
        win_len = lens[win];
        bad_len = (win_len == 16'd0) ||
                  (win_len[1:0] != 2'd0) ||
                  (32'(win_len) > MAX_LEN);
    end

    always_comb begin
        state_n = state;
        grant   = 1'b0;
        done    = 1'b0;
        abort   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (bus.tx_rdy && found) begin
                    grant   = 1'b1;
                    state_n = bad_len ? S_REJ : S_LOAD;
                end
            end
            S_LOAD: begin
                if (cnt == CW'(2)) begin
                    state_n = S_SEND;
                end
            end
            S_SEND: begin
                if (bus.snd_end_tx) begin
                    done    = 1'b1;
                    state_n = S_GAP;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    abort   = 1'b1;
                    state_n = S_GAP;
                end
            end
            S_GAP: begin
                if (cnt == CW'(GAP - 1)) begin
                    state_n = S_IDLE;
                end
            end
            S_REJ: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state, so the sender
    // sees snd_en low exactly while the scheduler is in SEND.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state              <= S_IDLE;
            cnt                <= '0;
            rr_ptr             <= '0;
            bus.snd_en         <= 1'b1;
            bus.busy           <= 1'b0;
            bus.ack            <= '0;
            bus.err            <= 1'b0;
            bus.frame_cnt      <= '0;
            bus.mem_sel        <= '0;
            bus.snd_channel    <= 8'(CH_BASE);
            bus.snd_mem_length <= '0;
            bus.snd_time_buf   <= '0;
        end else begin
            state      <= state_n;
            cnt        <= (state_n != state) ? '0 : cnt + 1'b1;
            bus.snd_en <= (state_n != S_SEND);
            bus.busy   <= (state_n != S_IDLE);
            bus.ack    <= '0;
            bus.err    <= 1'b0;
            if (grant) begin
                bus.mem_sel        <= win;
                bus.snd_channel    <= 8'(CH_BASE) + {5'd0, win};
                bus.snd_mem_length <= win_len;
                bus.snd_time_buf   <= bus.time_in;
                rr_ptr <= (win == 3'(N_CH - 1)) ? 3'd0 : win + 3'd1;
            end
            if (grant && bad_len) begin
                bus.ack <= onehot(win);
                bus.err <= 1'b1;
            end
            if (done || abort) begin
                bus.ack <= onehot(bus.mem_sel);
                bus.err <= abort;
            end
            if (done) begin
                bus.frame_cnt <= bus.frame_cnt + 16'd1;
            end
        end
    end
endmodule

// File: doc/udp_tx_scheduler.md
# udp_tx_scheduler

Round-robin scheduler that shares the single `udp_sender` frame engine between N channel sources. It latches a requesting channel's payload length, channel number and timestamp, and sequences the sender's `en` / `END_TX` handshake. It steers the sender's payload-memory read port to the granted channel's buffer and enforces an inter-frame gap. It also recovers from a sender that never completes a frame. It sits between the per-channel capture buffers and `udp_sender`, in the `clk` domain of the MAC TX interface.

## Interface
- `N_CH`, default 4: number of requesting channels, 2..8.
- `CH_BASE`, default 0: channel number sent for requester 0; requester i sends `CH_BASE+i`.
- `MAX_LEN`, default 1024: largest accepted payload length in bytes.
- `GAP`, default 16: idle cycles between `END_TX` and the next load, 1..255.
- `TIMEOUT`, default 8192: cycle limit for the SEND state before abort.
- `clk`, in, 1: the only clock.
- `rst_n`, in, 1: synchronous reset, active low.
- `req`, in, N_CH: per-channel frame request; a level held until the matching `ack`.
- `len_in`, in, 16*N_CH: payload byte length of channel i at bits [16i+15:16i], sampled at grant.
- `time_in`, in, 32: free-running time stamp, sampled at grant.
- `tx_rdy`, in, 1: MAC TX ready, the same signal that feeds `udp_sender`.
- `snd_end_tx`, in, 1: `END_TX` from `udp_sender`.
- `snd_en`, out, 1: drives `udp_sender.en`.
- `snd_channel`, out, 8: drives `channel`.
- `snd_mem_length`, out, 16: drives `mem_length`.
- `snd_time_buf`, out, 32: drives `time_buf`.
- `mem_sel`, out, 3: index of the buffer muxed onto `mem_data`.
- `ack`, out, N_CH: one-cycle completion pulse to the granted channel.
- `err`, out, 1: one-cycle pulse accompanying `ack` on a rejected or aborted frame.
- `busy`, out, 1: high in every state except IDLE.
- `frame_cnt`, out, 16: count of frames sent successfully; wraps at 65535 to 0.

## Operation
- States are IDLE, LOAD, SEND, GAP and REJ.
- In IDLE, the state advances only when `tx_rdy`=1 and `req`≠0. Round-robin selection starts at (last granted index + 1) mod N_CH; after reset the search starts at index 0.
  - If the winner's length is 0, has `len[1:0]`≠0, or exceeds `MAX_LEN`, the next state is REJ.
  - Otherwise the next state is LOAD.
  - The grant registers `mem_sel`, `snd_channel`, `snd_mem_length` and `snd_time_buf`. These hold constant until the next grant.
- LOAD lasts exactly 3 cycles with `snd_en`=1. This lets the sender's registered `Length`/`Total_length` settle and then its header checksum settle before the frame starts. Then the state goes to SEND.
- In SEND, `snd_en`=0 and the sender runs. A watchdog counter starts at 0 on entry.
  - `snd_end_tx`=1: pulse `ack[g]`, increment `frame_cnt`, go to GAP.
  - Watchdog reaches `TIMEOUT`-1 first: pulse `ack[g]` and `err`, leave `frame_cnt` unchanged, go to GAP.
  - `tx_rdy` dropping during SEND is not an error in itself; the sender restarts the frame and the watchdog keeps counting.
- In GAP, `snd_en`=1 for `GAP` cycles, then the state goes to IDLE. `snd_en` must stay 1 in IDLE, GAP, REJ and reset, so the sender stays parked.
- REJ lasts one cycle: pulse `ack[g]` and `err`, then go to IDLE. The round-robin pointer advances past g.
- A requester whose `req` is still high after its `ack` is served again in its next round-robin turn. The requester is responsible for dropping `req` in the cycle after `ack` if it has no new frame.
- `req` bits that drop before grant are simply not considered. `req` changes after grant do not affect the frame in flight.

## Timing
- Reset values, while `rst_n`=0 at a clock edge: state IDLE, `snd_en`=1, `busy`=0, `ack`=0, `err`=0, `frame_cnt`=0, `mem_sel`=0, `snd_channel`=`CH_BASE`, `snd_mem_length`=0, `snd_time_buf`=0, round-robin pointer at 0.
- Reset asserted mid-SEND returns to these values on the next edge. `snd_en`=1 aborts the sender. No `ack` is produced.
- Latency from `req` to the first sender cycle:
  - Cycle 0: `req` is sampled in IDLE.
  - Cycles 1-3: LOAD.
  - Cycle 4: `snd_en` falls and the sender starts its MAC header on the following edge.
- `snd_end_tx` is seen at edge k. `ack`/`frame_cnt` update at edge k+1. The first IDLE cycle is k+1+`GAP`.
- `snd_end_tx` outside SEND is ignored.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- The watchdog is at least 14 bits wide. `TIMEOUT` must exceed the worst-case frame time, (`MAX_LEN`/4)+20 cycles.

## Test plan
- Single frame: `req`=0001, `len0`=32, `time_in`=0x12345678. Required: `snd_en` low for exactly the SEND window, `snd_channel`=0, `snd_mem_length`=32, `snd_time_buf`=0x12345678. When the END_TX model fires after 20 cycles, `ack`=0001 pulses once and `frame_cnt`=1.
- Fairness: `req`=1111 held with all lengths 64. Required: grants in order 0,1,2,3,0. Each `ack` is followed by exactly `GAP`=16 cycles with `snd_en`=1 before the next LOAD.
- Rejects: `len1`=0, then 6, then 2048, with `req`=0010. Required: `ack[1]`+`err` one cycle after grant each time, no LOAD, `snd_en` stays 1, `frame_cnt` unchanged.
- Timeout: the END_TX model is silent and `TIMEOUT`=8192. Required: `ack`+`err` at SEND cycle 8192, then GAP, and `frame_cnt` not incremented.
- Backpressure: `tx_rdy`=0 while `req`=0001. Required: stays IDLE, `busy`=0. `tx_rdy`→1 gives LOAD on the next cycle. Dropping `tx_rdy` mid-SEND for 5 cycles still completes with `ack`.
- Reset mid-frame: `rst_n`=0 for 1 cycle during SEND. Required: next edge shows `snd_en`=1, `busy`=0, `frame_cnt`=0, no `ack`. The frame is re-granted afterwards if `req` is still high.
